// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM fill/readback test FSMs.
// Writers and the readback checker take their data pattern from the same
// function, so both ends always agree on what the RAM should hold.
package lutram_test_pkg;

    // Sweep controller states; all four 2-bit codes are used.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Data pattern codes.
    localparam logic [1:0] PAT_ADDR0  = 2'd0;  // data = addr[0]
    localparam logic [1:0] PAT_NADDR0 = 2'd1;  // data = ~addr[0]
    localparam logic [1:0] PAT_ZERO   = 2'd2;  // data = 0
    localparam logic [1:0] PAT_ONE    = 2'd3;  // data = 1

    // Expected RAM bit for an address. Only the address LSB matters for
    // any of the defined patterns, so callers pass just that bit.
    function automatic logic expected_bit(input logic addr_lsb, input logic [1:0] pattern);
        logic bit_val;
        case (pattern)
            PAT_ADDR0:  bit_val = addr_lsb;
            PAT_NADDR0: bit_val = ~addr_lsb;
            PAT_ZERO:   bit_val = 1'b0;
            default:    bit_val = 1'b1;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/lutram_readback_checker.sv
// Readback checker for a single-bit distributed RAM.
// Sweeps every address once, samples the asynchronous read data one edge
// after presenting the address, compares it with the shared pattern and
// reports a saturating mismatch count, the first failing address and pass.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH   = 7,
    parameter int PATTERN   = 0,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 q_i,
    output logic [A_WIDTH-1:0]   addr_o,
    output logic                 rd_active_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic [A_WIDTH-1:0]   first_err_addr_o
);

    localparam logic [1:0]           PAT_SEL   = PATTERN[1:0];
    localparam logic [A_WIDTH-1:0]   ADDR_LAST = '1;
    localparam logic [A_WIDTH-1:0]   ADDR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE   = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_clear;      // start accepted: restart sweep
    logic                   w_capture;    // sample q_i at this edge

    logic [A_WIDTH-1:0]     r_addr;
    logic                   r_sample_valid;
    logic                   r_sample_q;
    logic [A_WIDTH-1:0]     r_sample_addr;
    logic                   w_mismatch;

    logic [ERR_WIDTH-1:0]   r_err_count;
    logic [A_WIDTH-1:0]     r_first_err_addr;

    // State register; reset wins over a simultaneous start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = READ;
                    w_clear      = 1'b1;
                end
            end
            READ: begin
                w_capture = 1'b1;
                if (r_addr == ADDR_LAST) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = DONE;
            end
            DONE: begin
                if (start_i) begin
                    w_next_state = READ;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Read address: cleared on start, stepped while reading, parked at the
    // last address once the sweep reaches it (no wrap).
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_addr <= '0;
        end else if (w_capture && (r_addr != ADDR_LAST)) begin
            r_addr <= r_addr + ADDR_ONE;
        end
    end

    // Sample-valid flag: set by every READ capture, dropped on the edge
    // that leaves DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_capture;
        end
    end

    // Sample data and address captured together from the RAM read port.
    // NOTE: these data registers carry no reset; r_sample_valid gates every
    // use of them, so their power-up content never reaches an output.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_sample_q    <= q_i;
            r_sample_addr <= r_addr;
        end
    end

    assign w_mismatch = r_sample_valid &&
                        (r_sample_q != expected_bit(r_sample_addr[0], PAT_SEL));

    // Saturating mismatch counter plus the address of the first mismatch.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else if (w_mismatch) begin
            if (r_err_count == '0) begin
                r_first_err_addr <= r_sample_addr;
            end
            if (r_err_count != ERR_MAX) begin
                r_err_count <= r_err_count + ERR_ONE;
            end
        end
    end

    assign addr_o           = r_addr;
    assign rd_active_o      = (r_state == READ) || (r_state == DRAIN);
    assign done_o           = (r_state == DONE);
    assign pass_o           = done_o && (r_err_count == '0);
    assign err_count_o      = r_err_count;
    assign first_err_addr_o = r_first_err_addr;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Bench for lutram_readback_checker. Three instances share one clock:
//   0: PATTERN=0, ERR_WIDTH=8   1: PATTERN=0, ERR_WIDTH=4   2: PATTERN=2, ERR_WIDTH=8
// Each has its own behavioural 128x1 asynchronous-read RAM. Expected
// results are computed from RAM contents when a sweep starts, queued, and
// compared when done_o rises.
module tb_lutram_readback_checker;

    typedef struct {
        int edges;
        int errs;
        int first;
        bit pass;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] start;

    logic ram0 [128];
    logic ram1 [128];
    logic ram2 [128];

    logic [6:0] addr0, addr1, addr2;
    logic [6:0] first0, first1, first2;
    logic       q0, q1, q2;
    logic       act0, act1, act2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [7:0] err0;
    logic [3:0] err1;
    logic [7:0] err2;

    assign q0 = ram0[addr0];
    assign q1 = ram1[addr1];
    assign q2 = ram2[addr2];

    lutram_readback_checker #(.A_WIDTH(7), .PATTERN(0), .ERR_WIDTH(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .q_i(q0),
        .addr_o(addr0), .rd_active_o(act0), .done_o(done0), .pass_o(pass0),
        .err_count_o(err0), .first_err_addr_o(first0)
    );

    lutram_readback_checker #(.A_WIDTH(7), .PATTERN(0), .ERR_WIDTH(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .q_i(q1),
        .addr_o(addr1), .rd_active_o(act1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .first_err_addr_o(first1)
    );

    lutram_readback_checker #(.A_WIDTH(7), .PATTERN(2), .ERR_WIDTH(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .q_i(q2),
        .addr_o(addr2), .rd_active_o(act2), .done_o(done2), .pass_o(pass2),
        .err_count_o(err2), .first_err_addr_o(first2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_addr(input int s);
        return (s == 0) ? int'(addr0) : (s == 1) ? int'(addr1) : int'(addr2);
    endfunction
    function automatic int get_first(input int s);
        return (s == 0) ? int'(first0) : (s == 1) ? int'(first1) : int'(first2);
    endfunction
    function automatic int get_err(input int s);
        return (s == 0) ? int'(err0) : (s == 1) ? int'(err1) : int'(err2);
    endfunction
    function automatic int get_act(input int s);
        return (s == 0) ? int'(act0) : (s == 1) ? int'(act1) : int'(act2);
    endfunction
    function automatic int get_done(input int s);
        return (s == 0) ? int'(done0) : (s == 1) ? int'(done1) : int'(done2);
    endfunction
    function automatic int get_pass(input int s);
        return (s == 0) ? int'(pass0) : (s == 1) ? int'(pass1) : int'(pass2);
    endfunction
    function automatic logic get_ram(input int s, input int a);
        logic [6:0] ai;
        ai = a[6:0];
        return (s == 0) ? ram0[ai] : (s == 1) ? ram1[ai] : ram2[ai];
    endfunction

    // Reference pattern, written independently of the design package.
    function automatic logic ref_bit(input int pat, input int a);
        case (pat)
            0:       return ((a % 2) == 1);
            1:       return ((a % 2) == 0);
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Expected result of a full sweep of instance s over its current RAM.
    function automatic exp_t model(input int s);
        exp_t e;
        int   pat;
        int   max_err;
        pat     = (s == 2) ? 2 : 0;
        max_err = (s == 1) ? 15 : 255;
        e.edges = 129;
        e.errs  = 0;
        e.first = 0;
        for (int a = 0; a < 128; a++) begin
            if (get_ram(s, a) != ref_bit(pat, a)) begin
                if (e.errs == 0) e.first = a;
                if (e.errs < max_err) e.errs++;
            end
        end
        e.pass = (e.errs == 0);
        return e;
    endfunction

    task automatic set_start(input int s, input logic v);
        start[s] = v;
    endtask

    // Pulse (or hold) start for instance s; checks the edge that accepts it.
    task automatic start_sweep(input int s, input bit push, input bit hold);
        if (push) sb_q.push_back(model(s));
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        check("start_done_low", get_done(s), 0);
        check("start_err_clear", get_err(s), 0);
        check("start_rd_active", get_act(s), 1);
        check("start_addr_zero", get_addr(s), 0);
        if (!hold) set_start(s, 1'b0);
    endtask

    // Count edges after the start edge until done_o, then score the result.
    task automatic wait_done(input int s);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 100) set_start(s, 1'b0);
            seen = (get_done(s) == 1);
        end
        if (!seen) check("done_timeout", 0, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("done_latency", n, e.edges);
            check("err_count", get_err(s), e.errs);
            if (e.errs != 0) check("first_err_addr", get_first(s), e.first);
            check("pass", get_pass(s), int'(e.pass));
            check("addr_hold_max", get_addr(s), 127);
            check("rd_active_after_drain", get_act(s), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        rst   = '1;
        start = '0;
        for (int a = 0; a < 128; a++) begin
            ram0[a] = (a % 2 == 1);
            ram1[a] = (a % 2 == 0);
            ram2[a] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", get_addr(0), 0);
        check("rst_err", get_err(0), 0);
        check("rst_first", get_first(0), 0);
        check("rst_done", get_done(0), 0);
        check("rst_pass", get_pass(0), 0);
        check("rst_rd_active", get_act(0), 0);
        @(negedge clk);
        rst = '0;

        // Clean addr[0] pattern.
        start_sweep(0, 1'b1, 1'b0);
        wait_done(0);

        // Two flipped bits.
        ram0[5]  = ~ram0[5];
        ram0[77] = ~ram0[77];
        start_sweep(0, 1'b1, 1'b0);
        wait_done(0);

        // Fully inverted RAM on the 4-bit counter instance: saturates at 15.
        start_sweep(1, 1'b1, 1'b0);
        wait_done(1);

        // Reset in the middle of a sweep that has already seen an error.
        ram0[77] = ~ram0[77];
        start_sweep(0, 1'b0, 1'b0);
        n = 0;
        while (get_addr(0) != 40 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_addr_40", get_addr(0), 40);
        check("mid_err_seen", get_err(0), 1);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check("midrst_addr", get_addr(0), 0);
        check("midrst_err", get_err(0), 0);
        check("midrst_first", get_first(0), 0);
        check("midrst_done", get_done(0), 0);
        check("midrst_pass", get_pass(0), 0);
        check("midrst_rd_active", get_act(0), 0);
        ram0[5] = ~ram0[5];
        start_sweep(0, 1'b1, 1'b0);
        wait_done(0);

        // start held high through READ must not restart the sweep.
        start_sweep(0, 1'b1, 1'b1);
        wait_done(0);

        // Two-error run, then restart from DONE with a clean RAM.
        ram0[5]  = ~ram0[5];
        ram0[77] = ~ram0[77];
        start_sweep(0, 1'b1, 1'b0);
        wait_done(0);
        ram0[5]  = ~ram0[5];
        ram0[77] = ~ram0[77];
        start_sweep(0, 1'b1, 1'b0);
        wait_done(0);

        // All-zero pattern, then a single 1 at the last address.
        start_sweep(2, 1'b1, 1'b0);
        wait_done(2);
        ram2[127] = 1'b1;
        start_sweep(2, 1'b1, 1'b0);
        wait_done(2);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
